// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sizing constants and the thread id type for the fetch stage
package fetch_pkg;
  localparam int THREAD_INDEX_BITS = 3;
  localparam int NUM_THREADS = 2 ** THREAD_INDEX_BITS;
  localparam int ADDR_WIDTH = 32;
  localparam int INSTR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;
  localparam int PC_INCREMENT = 4;
  typedef logic [THREAD_INDEX_BITS-1:0] thread_id_t;
endpackage

// File: rtl/rr_thread_arbiter.sv
// rr_thread_arbiter: combinational round-robin pick of the first enabled thread after pointer
// Ports: mask (eligible threads), pointer (last issued), grant_valid, grant_idx
module rr_thread_arbiter
  import fetch_pkg::*;
#(
  parameter int BITS = THREAD_INDEX_BITS
) (
  input  logic [2**BITS-1:0] mask,
  input  logic [BITS-1:0]    pointer,
  output logic               grant_valid,
  output logic [BITS-1:0]    grant_idx
);
  // Scan from farthest to nearest so the nearest enabled thread after pointer wins;
  // offset 2**BITS wraps back onto pointer itself, giving it the lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    for (int k = 2 ** BITS; k >= 1; k--) begin
      if (mask[pointer + BITS'(k)]) begin
        grant_valid = 1'b1;
        grant_idx = pointer + BITS'(k);
      end
    end
  end
endmodule

// File: rtl/fetch_thread_scheduler.sv
// fetch_thread_scheduler: per-thread PCs, round-robin thread pick, imem addressing, fetch/decode outputs
// Ports: clk, reset (sync, active-high); in_thread_enable run mask; in_stall freezes fetch;
//   in_redirect_valid/thread/pc overwrite one thread PC and squash its fetches;
//   out_imem_en/out_imem_addr drive imem, in_imem_data returns one cycle later;
//   out_instruction/out_thread_index/out_pc/out_instruction_valid feed the fetch/decode regs.
// Option: FETCH_PERF_COUNTERS_EN adds out_fetch_count, one saturating 32-bit counter per thread.
module fetch_thread_scheduler
  import fetch_pkg::PC_INCREMENT;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int THREAD_INDEX_BITS = 3,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [2**THREAD_INDEX_BITS-1:0]     in_thread_enable,
  input  logic                                in_stall,
  input  logic                                in_redirect_valid,
  input  logic [THREAD_INDEX_BITS-1:0]        in_redirect_thread,
  input  logic [ADDR_WIDTH-1:0]               in_redirect_pc,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [(2**THREAD_INDEX_BITS)*32-1:0] out_fetch_count,
`endif
  output logic                                out_imem_en,
  output logic [ADDR_WIDTH-1:0]               out_imem_addr,
  input  logic [INSTR_WIDTH-1:0]              in_imem_data,
  output logic [INSTR_WIDTH-1:0]              out_instruction,
  output logic [THREAD_INDEX_BITS-1:0]        out_thread_index,
  output logic [ADDR_WIDTH-1:0]               out_pc,
  output logic                                out_instruction_valid
);
  localparam int NUM_THREADS = 2 ** THREAD_INDEX_BITS;
  logic [ADDR_WIDTH-1:0] pc [NUM_THREADS];
  logic [THREAD_INDEX_BITS-1:0] pointer, grant_idx;
  logic grant_valid, issue, squash_issue, squash_held;
  rr_thread_arbiter #(.BITS(THREAD_INDEX_BITS)) arb (
    .mask(in_thread_enable),
    .pointer(pointer),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );
  assign issue = grant_valid && !in_stall && !reset;
  // A redirect kills both the fetch leaving this cycle and a held wrong-path instruction of that thread
  assign squash_issue = in_redirect_valid && in_redirect_thread == grant_idx;
  assign squash_held = in_redirect_valid && in_redirect_thread == out_thread_index && out_instruction_valid;
  assign out_imem_en = issue;
  assign out_imem_addr = pc[grant_idx];
  assign out_instruction = in_imem_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) pc[i] <= RESET_PC;
      pointer <= '1;
      out_instruction_valid <= 1'b0;
      out_thread_index <= '0;
      out_pc <= '0;
    end else begin
      if (issue) begin
        pc[grant_idx] <= pc[grant_idx] + ADDR_WIDTH'(PC_INCREMENT);
        pointer <= grant_idx;
        out_thread_index <= grant_idx;
        out_pc <= pc[grant_idx];
        out_instruction_valid <= !squash_issue;
      end else if (!in_stall || squash_held) out_instruction_valid <= 1'b0;
      // Placed after the increment so a redirect overrides +4 on the same thread
      if (in_redirect_valid) pc[in_redirect_thread] <= in_redirect_pc;
    end
  end
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count [NUM_THREADS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (reset) fetch_count[i] <= '0;
      else if (issue && !squash_issue && grant_idx == THREAD_INDEX_BITS'(i) && !(&fetch_count[i]))
        fetch_count[i] <= fetch_count[i] + 32'd1;
    end
  end
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_count
    assign out_fetch_count[32*t+:32] = fetch_count[t];
  end
`endif
endmodule

// File: tb/tb_fetch_thread_scheduler.sv
// tb_fetch_thread_scheduler: scoreboard bench for the round-robin fetch thread scheduler
module tb_fetch_thread_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] en = 8'hFF;
  logic stall = 1'b0, rv = 1'b0;
  logic [2:0] rt = '0;
  logic [31:0] rpc = '0, imem_data = '0;
  logic imem_en, ovalid;
  logic [31:0] imem_addr, instr, opc;
  logic [2:0] tid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [255:0] fetch_count;
`endif
  fetch_thread_scheduler dut (
    .clk(clk),
    .reset(reset),
    .in_thread_enable(en),
    .in_stall(stall),
    .in_redirect_valid(rv),
    .in_redirect_thread(rt),
    .in_redirect_pc(rpc),
`ifdef FETCH_PERF_COUNTERS_EN
    .out_fetch_count(fetch_count),
`endif
    .out_imem_en(imem_en),
    .out_imem_addr(imem_addr),
    .in_imem_data(imem_data),
    .out_instruction(instr),
    .out_thread_index(tid),
    .out_pc(opc),
    .out_instruction_valid(ovalid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction
  always @(posedge clk) if (imem_en) imem_data <= imem_word(imem_addr);
  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
  } item_t;
  item_t sb[$];
  item_t trace[$];
  int checks = 0, failures = 0;
  logic [31:0] mpc [8];
  logic [2:0] mptr = 3'd7, mtid = '0;
  logic [31:0] mopc = '0;
  logic mvalid = 1'b0;

  task automatic step();
    logic gv, iss;
    logic [2:0] g, c;
    logic [31:0] a;
    item_t e;
    #1;
    gv = 1'b0;
    g = '0;
    c = mptr;
    repeat (8) begin
      c = c + 3'd1;
      if (!gv && en[c]) begin
        gv = 1'b1;
        g = c;
      end
    end
    iss = gv && !stall;
    a = mpc[g];
    checks++;
    if (imem_en !== iss) begin
      failures++;
      $display("FAIL imem_en got=%b exp=%b at %0t", imem_en, iss, $time);
    end
    if (iss) begin
      checks++;
      if (imem_addr !== a) begin
        failures++;
        $display("FAIL imem_addr got=%h exp=%h thread=%0d at %0t", imem_addr, a, g, $time);
      end
      trace.push_back('{g, a});
    end
    @(posedge clk);
    if (!stall) begin
      if (iss) begin
        mpc[g] = a + 32'd4;
        mptr = g;
        mtid = g;
        mopc = a;
        mvalid = !(rv && rt == g);
        if (mvalid) sb.push_back('{g, a});
      end else mvalid = 1'b0;
    end else if (rv && rt == mtid) mvalid = 1'b0;
    if (rv) mpc[rt] = rpc;
    #1;
    checks++;
    if (ovalid !== mvalid) begin
      failures++;
      $display("FAIL valid got=%b exp=%b at %0t", ovalid, mvalid, $time);
    end
    checks++;
    if (tid !== mtid || opc !== mopc) begin
      failures++;
      $display("FAIL out_regs got t=%0d pc=%h exp t=%0d pc=%h at %0t", tid, opc, mtid, mopc, $time);
    end
    if (iss && mvalid && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (tid !== e.t || opc !== e.a || instr !== imem_word(e.a)) begin
        failures++;
        $display("FAIL scoreboard got t=%0d pc=%h ins=%h exp t=%0d pc=%h ins=%h", tid, opc, instr, e.t, e.a, imem_word(e.a));
      end
    end else if (mvalid) begin
      checks++;
      if (instr !== imem_word(mopc)) begin
        failures++;
        $display("FAIL held_instr got=%h exp=%h at %0t", instr, imem_word(mopc), $time);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = 8'hFF;
    stall = 1'b0;
    rv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (imem_en !== 1'b0 || ovalid !== 1'b0 || tid !== 3'd0 || opc !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got en=%b v=%b t=%0d pc=%h exp 0 0 0 0", imem_en, ovalid, tid, opc);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mpc[i] = '0;
    mptr = 3'd7;
    mtid = '0;
    mopc = '0;
    mvalid = 1'b0;
    sb.delete();
    trace.delete();
  endtask

  task automatic test_round_robin();
    test_reset();
    repeat (9) step();
    checks++;
    if (trace.size() != 9) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=9", trace.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (trace[i].t !== 3'(i % 8) || trace[i].a !== (i < 8 ? 32'd0 : 32'd4)) begin
          failures++;
          $display("FAIL rr_order[%0d] got t=%0d a=%h exp t=%0d a=%h", i, trace[i].t, trace[i].a, i % 8, i < 8 ? 0 : 4);
        end
      end
    end
  endtask

  task automatic test_two_threads();
    logic [2:0] et [4];
    logic [31:0] ea [4];
    et = '{3'd0, 3'd2, 3'd0, 3'd2};
    ea = '{32'd0, 32'd0, 32'd4, 32'd4};
    test_reset();
    en = 8'b0000_0101;
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (trace.size() != 4 || trace[i].t !== et[i] || trace[i].a !== ea[i]) begin
        failures++;
        $display("FAIL two_thread[%0d] exp t=%0d a=%h size=%0d", i, et[i], ea[i], trace.size());
      end
    end
    for (int t = 1; t < 8; t += 2) begin
      en = 8'd1 << t;
      trace.delete();
      step();
      checks++;
      if (trace.size() != 1 || trace[0].t !== 3'(t) || trace[0].a !== 32'd0) begin
        failures++;
        $display("FAIL idle_pc thread=%0d exp addr 0 size=%0d", t, trace.size());
      end
    end
  endtask

  task automatic test_stall();
    en = 8'hFF;
    trace.delete();
    repeat (3) step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (3) step();
    checks++;
    if (trace.size() != 6) begin
      failures++;
      $display("FAIL stall_issues got=%0d exp=6", trace.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (trace[i+1].t !== trace[i].t + 3'd1) begin
          failures++;
          $display("FAIL stall_seq[%0d] got=%0d exp=%0d", i, trace[i+1].t, trace[i].t + 3'd1);
        end
      end
    end
  endtask

  task automatic test_redirect_held();
    en = 8'b0000_0100;
    repeat (2) step();
    rv = 1'b1;
    rt = 3'd2;
    rpc = 32'h100;
    step();
    rv = 1'b0;
    checks++;
    if (ovalid !== 1'b0) begin
      failures++;
      $display("FAIL squash_held got valid=%b exp=0", ovalid);
    end
    trace.delete();
    step();
    checks++;
    if (trace.size() != 1 || trace[0].a !== 32'h100) begin
      failures++;
      $display("FAIL redirect_addr exp=00000100 size=%0d", trace.size());
    end
  endtask

  task automatic test_redirect_issue();
    int n = 0;
    en = 8'hFF;
    while (mptr != 3'd4 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n >= 10) begin
      failures++;
      $display("FAIL wait_thread4 budget expired got ptr=%0d exp=4", mptr);
    end
    rv = 1'b1;
    rt = 3'd5;
    rpc = 32'h200;
    trace.delete();
    step();
    rv = 1'b0;
    checks++;
    if (trace.size() != 1 || trace[0].t !== 3'd5 || ovalid !== 1'b0) begin
      failures++;
      $display("FAIL squash_issue got valid=%b exp=0 size=%0d", ovalid, trace.size());
    end
    trace.delete();
    repeat (8) step();
    checks++;
    if (trace.size() != 8 || trace[7].t !== 3'd5 || trace[7].a !== 32'h200) begin
      failures++;
      $display("FAIL redirect_no_inc exp t=5 a=00000200 size=%0d", trace.size());
    end
  endtask

  task automatic test_disable();
    logic [2:0] nt;
    logic [31:0] na;
    en = 8'h00;
    repeat (4) step();
    #1;
    checks++;
    if (imem_en !== 1'b0 || ovalid !== 1'b0) begin
      failures++;
      $display("FAIL disabled got en=%b valid=%b exp 0 0", imem_en, ovalid);
    end
    nt = mptr + 3'd1;
    na = mpc[nt];
    en = 8'hFF;
    trace.delete();
    step();
    checks++;
    if (trace.size() != 1 || trace[0].t !== nt || trace[0].a !== na) begin
      failures++;
      $display("FAIL resume exp t=%0d a=%h size=%0d", nt, na, trace.size());
    end
  endtask

  initial begin
    test_round_robin();
    test_two_threads();
    test_round_robin();
    test_stall();
    test_redirect_held();
    test_redirect_issue();
    test_disable();
    repeat (3) step();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
